// File: rtl/spi_reg_pkg.sv
// Shared definitions for the SPI register responder: frame layout constants
// and the frame-decoder state encoding.
package spi_reg_pkg;

    localparam int   SPI_BYTE_W = 8;
    localparam int   SPI_RW_BIT = 7;
    localparam logic SPI_READ   = 1'b1;

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_ADDR    = 3'd1,
        S_RD_REQ  = 3'd2,
        S_RD_LOAD = 3'd3,
        S_RD_DATA = 3'd4,
        S_WR_DATA = 3'd5,
        S_WAIT_CE = 3'd6
    } state_t;

endpackage

// File: rtl/spi_in_sync.sv
// Multi-bit input synchronizer with single-cycle rise/fall pulses.
// SYNC_STAGES flops bring the signal into the clk domain, and one more flop
// holds the previous synchronized value for edge detection. All flops clear
// to 0, so a line that is already low at reset release never produces a
// spurious falling edge.
module spi_in_sync #(
    parameter int SYNC_STAGES = 2,
    parameter int W           = 1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [W-1:0] d_i,
    output logic [W-1:0] rise_o,
    output logic [W-1:0] fall_o
);

    logic [W-1:0] stage_q [SYNC_STAGES];
    logic [W-1:0] prev_q;

    // Synchronizer chain followed by the edge-detect history flop.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < SYNC_STAGES; i++) stage_q[i] <= '0;
            prev_q <= '0;
        end else begin
            stage_q[0] <= d_i;
            for (int i = 1; i < SYNC_STAGES; i++) stage_q[i] <= stage_q[i-1];
            prev_q <= stage_q[SYNC_STAGES-1];
        end
    end

    assign rise_o = stage_q[SYNC_STAGES-1] & ~prev_q;
    assign fall_o = ~stage_q[SYNC_STAGES-1] & prev_q;

endmodule

// File: rtl/spi_reg_slave8.sv
// SPI mode-0 register responder. Oversamples CE/SCLK/MOSI in the clk domain,
// decodes {R/W, addr[6:0]} + one data byte frames, drives a register-file
// port and returns read data on MISO with an output enable for the shared
// half-duplex line.
module spi_reg_slave8
    import spi_reg_pkg::*;
#(
    parameter int SYNC_STAGES = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       spi_ce,
    input  logic       spi_sclk,
    input  logic       spi_mosi,
    output logic       spi_miso,
    output logic       spi_oe,
    output logic [6:0] reg_addr,
    output logic       reg_wr_en,
    output logic [7:0] reg_wr_data,
    output logic       reg_rd_en,
    input  logic [7:0] reg_rd_data,
    output logic       busy,
    output logic       frame_err
);

    logic ce_rise, ce_fall, sclk_rise, sclk_fall;

    spi_in_sync #(.SYNC_STAGES(SYNC_STAGES), .W(1)) u_ce_sync (
        .clk    (clk),
        .rst    (rst),
        .d_i    (spi_ce),
        .rise_o (ce_rise),
        .fall_o (ce_fall)
    );

    spi_in_sync #(.SYNC_STAGES(SYNC_STAGES), .W(1)) u_sclk_sync (
        .clk    (clk),
        .rst    (rst),
        .d_i    (spi_sclk),
        .rise_o (sclk_rise),
        .fall_o (sclk_fall)
    );

    // MOSI needs only the level; its last stage lines up with the SCLK edge
    // detector so the bit sampled on sclk_rise is the one set up before it.
    logic [SYNC_STAGES-1:0] mosi_q;

    // MOSI synchronizer chain.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) mosi_q <= '0;
        else     mosi_q <= {mosi_q[SYNC_STAGES-2:0], spi_mosi};
    end

    state_t                state_q;
    logic [2:0]            bit_cnt_q;
    logic [SPI_BYTE_W-1:0] rx_q;
    logic [SPI_BYTE_W-1:0] rx_d;
    logic [SPI_BYTE_W-1:0] tx_q;
    logic                  rd_seen_q;
    logic                  byte_done;

    assign rx_d      = {rx_q[SPI_BYTE_W-2:0], mosi_q[SYNC_STAGES-1]};
    assign byte_done = sclk_rise && (bit_cnt_q == 3'd7);

    // Frame decoder: state, shift registers and all registered outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= S_IDLE;
            bit_cnt_q   <= 3'd0;
            rx_q        <= '0;
            tx_q        <= '0;
            rd_seen_q   <= 1'b0;
            spi_miso    <= 1'b0;
            spi_oe      <= 1'b0;
            reg_addr    <= 7'd0;
            reg_wr_en   <= 1'b0;
            reg_wr_data <= 8'd0;
            reg_rd_en   <= 1'b0;
            busy        <= 1'b0;
            frame_err   <= 1'b0;
        end else begin
            reg_wr_en <= 1'b0;
            reg_rd_en <= 1'b0;
            frame_err <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (ce_fall) begin
                        state_q   <= S_ADDR;
                        bit_cnt_q <= 3'd0;
                        busy      <= 1'b1;
                    end
                end
                S_WAIT_CE: begin
                    // A stray ce_fall here is ignored; only ce_rise ends the frame.
                    if (ce_rise) begin
                        state_q <= S_IDLE;
                        busy    <= 1'b0;
                    end
                end
                default: begin
                    if (ce_rise) begin
                        // CE released before the data byte completed.
                        state_q   <= S_IDLE;
                        spi_oe    <= 1'b0;
                        spi_miso  <= 1'b0;
                        busy      <= 1'b0;
                        frame_err <= 1'b1;
                    end else begin
                        if (sclk_rise) begin
                            bit_cnt_q <= bit_cnt_q + 3'd1;
                            if (state_q != S_RD_DATA) rx_q <= rx_d;
                        end
                        case (state_q)
                            S_ADDR: begin
                                if (byte_done) begin
                                    reg_addr <= rx_d[6:0];
                                    state_q  <= (rx_d[SPI_RW_BIT] == SPI_READ) ? S_RD_REQ : S_WR_DATA;
                                end
                            end
                            S_RD_REQ: begin
                                reg_rd_en <= 1'b1;
                                state_q   <= S_RD_LOAD;
                            end
                            S_RD_LOAD: begin
                                tx_q      <= reg_rd_data;
                                spi_oe    <= 1'b1;
                                spi_miso  <= reg_rd_data[7];
                                rd_seen_q <= 1'b0;
                                state_q   <= S_RD_DATA;
                            end
                            S_RD_DATA: begin
                                if (sclk_rise) begin
                                    rd_seen_q <= 1'b1;
                                    if (bit_cnt_q == 3'd7) begin
                                        spi_oe   <= 1'b0;
                                        spi_miso <= 1'b0;
                                        state_q  <= S_WAIT_CE;
                                    end
                                end else if (sclk_fall && rd_seen_q) begin
                                    // The fall closing the address byte arrives
                                    // before any data rise and must not shift.
                                    tx_q     <= {tx_q[SPI_BYTE_W-2:0], 1'b0};
                                    spi_miso <= tx_q[SPI_BYTE_W-2];
                                end
                            end
                            S_WR_DATA: begin
                                if (byte_done) begin
                                    reg_wr_data <= rx_d;
                                    reg_wr_en   <= 1'b1;
                                    state_q     <= S_WAIT_CE;
                                end
                            end
                            default: ;
                        endcase
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_spi_reg_slave8.sv
// Bench for spi_reg_slave8: acts as SPI master and register file, and checks
// the DUT against a frame-level model of expected register transactions.
module tb_spi_reg_slave8;

    logic       clk = 1'b0;
    logic       rst;
    logic       spi_ce, spi_sclk, spi_mosi;
    logic       spi_miso, spi_oe;
    logic [6:0] reg_addr;
    logic       reg_wr_en;
    logic [7:0] reg_wr_data;
    logic       reg_rd_en;
    logic [7:0] reg_rd_data;
    logic       busy, frame_err;

    int checks = 0;
    int passes = 0;

    logic [7:0] mem     [128];
    logic [7:0] exp_mem [128];
    int exp_wr_q [$];
    int exp_rd_q [$];
    int exp_err = 0;

    int         wr_count = 0, rd_count = 0, err_count = 0;
    logic [6:0] last_wr_addr = 7'd0, last_rd_addr = 7'd0;
    logic [7:0] last_wr_data = 8'd0;
    logic [7:0] rx_byte = 8'd0;
    logic       prev_wr = 1'b0, prev_rd = 1'b0, prev_err = 1'b0;
    int         e_val;

    always #5 clk = ~clk;

    spi_reg_slave8 #(.SYNC_STAGES(2)) dut (
        .clk         (clk),
        .rst         (rst),
        .spi_ce      (spi_ce),
        .spi_sclk    (spi_sclk),
        .spi_mosi    (spi_mosi),
        .spi_miso    (spi_miso),
        .spi_oe      (spi_oe),
        .reg_addr    (reg_addr),
        .reg_wr_en   (reg_wr_en),
        .reg_wr_data (reg_wr_data),
        .reg_rd_en   (reg_rd_en),
        .reg_rd_data (reg_rd_data),
        .busy        (busy),
        .frame_err   (frame_err)
    );

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act == exp) passes++;
        else $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic check_reset(input string tag);
        chk({tag, "_miso"},      spi_miso,    0);
        chk({tag, "_oe"},        spi_oe,      0);
        chk({tag, "_addr"},      reg_addr,    0);
        chk({tag, "_wr_en"},     reg_wr_en,   0);
        chk({tag, "_wr_data"},   reg_wr_data, 0);
        chk({tag, "_rd_en"},     reg_rd_en,   0);
        chk({tag, "_busy"},      busy,        0);
        chk({tag, "_frame_err"}, frame_err,   0);
    endtask

    // One SPI frame as master. nbits < 8 raises CE early; rst_bit >= 0 pulses
    // reset while SCLK is high on that data bit.
    task automatic frame(input logic [7:0] a, input logic [7:0] d, input int half,
                         input int nbits, input int extra, input int rst_bit);
        logic       is_rd;
        logic [7:0] expb;
        logic [7:0] got;
        is_rd = a[7];
        expb  = exp_mem[a[6:0]];
        got   = 8'd0;
        if (is_rd) exp_rd_q.push_back(int'(a[6:0]));
        if (!is_rd && nbits == 8 && rst_bit < 0) begin
            exp_wr_q.push_back((int'(a[6:0]) << 8) | int'(d));
            exp_mem[a[6:0]] = d;
        end
        if (nbits < 8 && rst_bit < 0) exp_err++;

        spi_ce = 1'b0;
        for (int i = 7; i >= 0; i--) begin
            spi_mosi = a[i];
            tick(half);
            if (i == 7) chk("busy_in_frame", busy, 1);
            chk("oe_addr_phase", spi_oe, 0);
            spi_sclk = 1'b1;
            tick(half);
            spi_sclk = 1'b0;
        end
        for (int k = 0; k < nbits; k++) begin
            spi_mosi = is_rd ? 1'($urandom) : d[7-k];
            tick(half);
            if (is_rd) begin
                chk("oe_data_phase", spi_oe, 1);
                chk("miso_bit", spi_miso, expb[7-k]);
                got[7-k] = spi_miso;
            end
            spi_sclk = 1'b1;
            if (k == rst_bit) begin
                tick(half / 2);
                #2 rst = 1'b1;
                #1 check_reset("async_rst");
                tick(3);
                spi_sclk = 1'b0;
                spi_ce   = 1'b1;
                tick(3);
                rst = 1'b0;
                tick(10);
                chk("post_rst_busy", busy, 0);
                return;
            end
            tick(half);
            spi_sclk = 1'b0;
        end
        rx_byte = got;
        for (int x = 0; x < extra; x++) begin
            spi_mosi = 1'($urandom);
            tick(half);
            spi_sclk = 1'b1;
            tick(half);
            spi_sclk = 1'b0;
        end
        tick(half);
        if (is_rd && nbits == 8) chk("oe_after_data", spi_oe, 0);
        spi_ce = 1'b1;
        tick(8);
        chk("busy_after_ce", busy, 0);
        chk("oe_after_ce", spi_oe, 0);
        tick(half);
    endtask

    // Compare process and register-file responder, sampled on the falling edge.
    initial begin
        reg_rd_data = 8'd0;
        forever begin
            @(negedge clk);
            if (rst) begin
                prev_wr  = 1'b0;
                prev_rd  = 1'b0;
                prev_err = 1'b0;
            end else begin
                if (reg_wr_en) begin
                    chk("wr_pulse_width", prev_wr, 0);
                    if (exp_wr_q.size() == 0) chk("wr_unexpected", 1, 0);
                    else begin
                        e_val = exp_wr_q.pop_front();
                        chk("wr_addr", reg_addr, e_val >> 8);
                        chk("wr_data", reg_wr_data, e_val & 255);
                    end
                    mem[reg_addr] = reg_wr_data;
                    last_wr_addr  = reg_addr;
                    last_wr_data  = reg_wr_data;
                    wr_count++;
                end
                if (reg_rd_en) begin
                    chk("rd_pulse_width", prev_rd, 0);
                    if (exp_rd_q.size() == 0) chk("rd_unexpected", 1, 0);
                    else chk("rd_addr", reg_addr, exp_rd_q.pop_front());
                    reg_rd_data  = mem[reg_addr];
                    last_rd_addr = reg_addr;
                    rd_count++;
                end else begin
                    reg_rd_data = 8'($urandom);
                end
                if (frame_err) begin
                    chk("err_pulse_width", prev_err, 0);
                    chk("err_expected", 1, (exp_err > 0) ? 1 : 0);
                    if (exp_err > 0) exp_err--;
                    err_count++;
                end
                if (!busy) chk("oe_while_idle", spi_oe, 0);
                prev_wr  = reg_wr_en;
                prev_rd  = reg_rd_en;
                prev_err = frame_err;
            end
        end
    end

    // Stimulus: directed frames from the test plan, then randomized frames.
    initial begin
        int c;
        logic [7:0] ra, rd;
        int half, nb, ex;
        rst      = 1'b1;
        spi_ce   = 1'b0;
        spi_sclk = 1'b0;
        spi_mosi = 1'b0;
        for (int i = 0; i < 128; i++) begin
            mem[i]     = 8'($urandom);
            exp_mem[i] = mem[i];
        end
        tick(3);
        check_reset("reset");

        // CE already low at reset release: no frame may start.
        rst = 1'b0;
        tick(20);
        chk("ce_low_release_busy", busy, 0);
        spi_ce = 1'b1;
        tick(10);
        chk("ce_release_busy", busy, 0);
        chk("ce_release_err", err_count, 0);

        frame(8'h15, 8'hA5, 50, 8, 0, -1);
        chk("dir_wr_count", wr_count, 1);
        chk("dir_wr_addr", last_wr_addr, 'h15);
        chk("dir_wr_data", last_wr_data, 'hA5);
        chk("dir_wr_err", err_count, 0);

        mem[10] = 8'h3C; exp_mem[10] = 8'h3C;
        frame(8'h8A, 8'h00, 50, 8, 0, -1);
        chk("dir_rd_count", rd_count, 1);
        chk("dir_rd_addr", last_rd_addr, 'h0A);
        chk("dir_rd_byte", rx_byte, 'h3C);

        mem[127] = 8'h81; exp_mem[127] = 8'h81;
        frame(8'hFF, 8'h00, 8, 8, 0, -1);
        chk("min_timing_byte", rx_byte, 'h81);

        c = wr_count;
        frame(8'h02, 8'hC3, 50, 5, 0, -1);
        chk("abort_no_wr", wr_count, c);
        chk("abort_err_count", err_count, 1);
        frame(8'h02, 8'h3E, 50, 8, 0, -1);
        chk("after_abort_wr", wr_count, c + 1);
        chk("after_abort_data", last_wr_data, 'h3E);

        frame(8'h03, 8'h55, 20, 8, 8, -1);
        chk("extra_clk_wr", wr_count, c + 2);
        chk("extra_clk_data", last_wr_data, 'h55);

        frame(8'h85, 8'h00, 20, 8, 0, 3);
        mem[1] = 8'h81; exp_mem[1] = 8'h81;
        frame(8'h81, 8'h00, 20, 8, 0, -1);
        chk("post_rst_rd_byte", rx_byte, 'h81);
        chk("post_rst_rd_addr", last_rd_addr, 'h01);

        for (int n = 0; n < 30; n++) begin
            ra   = 8'($urandom);
            rd   = 8'($urandom);
            half = $urandom_range(8, 20);
            nb   = ($urandom_range(0, 5) == 0) ? $urandom_range(1, 7) : 8;
            ex   = (nb == 8 && $urandom_range(0, 3) == 0) ? $urandom_range(1, 8) : 0;
            frame(ra, rd, half, nb, ex, -1);
        end

        tick(20);
        chk("wr_queue_drained", exp_wr_q.size(), 0);
        chk("rd_queue_drained", exp_rd_q.size(), 0);
        chk("err_all_seen", exp_err, 0);
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
